calc_sequencer: RTL and testbench

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_calc_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad calculator sequencer with bounded digit entry, iterative mul/div/mod
// and a level key-click tone request held until acknowledged.
module calc_sequencer #(
  parameter int MAX_DIGITS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  num,
  input  logic        num_pressed,
  input  logic [2:0]  opt,
  input  logic        opt_pressed,
  input  logic        submit,
  input  logic        tone_ack,
  output logic [7:0]  operand,
  output logic [15:0] result,
  output logic        result_valid,
  output logic        err,
  output logic        busy,
  output logic        tone_req,
  output logic [3:0]  tone_idx
);
  typedef enum logic [1:0] {ENTER_A, ENTER_B, COMPUTE, DONE} state_t;
  localparam logic [3:0] MAX_D = 4'(MAX_DIGITS);
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d, b_q, b_d, sh_q, sh_d, operand_q, operand_d;
  logic [15:0] acc_q, acc_d, result_q, result_d;
  logic [2:0]  op_q, op_d, it_q, it_d;
  logic [3:0]  dig_q, dig_d, tone_idx_q, tone_idx_d;
  logic        err_q, err_d, tone_req_q, tone_req_d, valid_q, valid_d, busy_q, busy_d;

  logic        is_clr, is_sub, is_op, is_dig, dig_ok, ovf, ge, is_mul;
  logic [7:0]  cur, dig_val, rem_n;
  logic [11:0] prod;
  logic [3:0]  dig_cnt;
  logic [15:0] mul_acc;
  logic [8:0]  rem_t;

  // Only the highest-priority event of a cycle is decoded.
  assign is_clr  = opt_pressed && opt >= 3'd5;
  assign is_sub  = submit && !is_clr;
  assign is_op   = opt_pressed && !is_clr && !submit;
  assign is_dig  = num_pressed && !opt_pressed && !submit && num <= 4'd9;

  assign cur     = state_q == ENTER_B ? b_q : a_q;
  assign prod    = {4'd0, cur} * 12'd10 + {8'd0, num};
  assign ovf     = prod > 12'd255;
  assign dig_val = ovf ? 8'hFF : prod[7:0];
  assign dig_ok  = dig_q < MAX_D;
  assign dig_cnt = (cur == 8'd0 && num == 4'd0) ? dig_q : dig_q + 4'd1;

  // Multiply walks the multiplier MSB-first; division is restoring, quotient shifts into sh.
  assign is_mul  = op_q == OP_MUL;
  assign mul_acc = (acc_q << 1) + (sh_q[7] ? {8'd0, a_q} : 16'd0);
  assign rem_t   = {acc_q[7:0], sh_q[7]};
  assign ge      = rem_t >= {1'b0, b_q};
  assign rem_n   = ge ? 8'(rem_t - {1'b0, b_q}) : rem_t[7:0];

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    dig_d      = dig_q;
    acc_d      = acc_q;
    sh_d       = sh_q;
    it_d       = it_q;
    result_d   = result_q;
    err_d      = err_q;
    tone_req_d = tone_req_q && !tone_ack;
    tone_idx_d = tone_idx_q;
    if (state_q != COMPUTE && is_clr) begin
      state_d    = ENTER_A;
      a_d        = 8'd0;
      b_d        = 8'd0;
      op_d       = 3'd0;
      dig_d      = 4'd0;
      it_d       = 3'd0;
      result_d   = 16'd0;
      err_d      = 1'b0;
      tone_req_d = 1'b1;
      tone_idx_d = 4'd15;
    end else begin
      case (state_q)
        ENTER_A, ENTER_B: begin
          if (is_sub) begin
            state_d    = state_q == ENTER_A ? DONE : COMPUTE;
            result_d   = state_q == ENTER_A ? {8'd0, a_q} : result_q;
            acc_d      = 16'd0;
            sh_d       = is_mul ? b_q : a_q;
            it_d       = 3'd0;
            tone_req_d = 1'b1;
            tone_idx_d = 4'd15;
          end else if (is_op) begin
            state_d    = ENTER_B;
            op_d       = opt;
            b_d        = state_q == ENTER_A ? 8'd0 : b_q;
            dig_d      = state_q == ENTER_A ? 4'd0 : dig_q;
            tone_req_d = 1'b1;
            tone_idx_d = {1'b0, opt} + 4'd10;
          end else if (is_dig && dig_ok) begin
            a_d        = state_q == ENTER_A ? dig_val : a_q;
            b_d        = state_q == ENTER_B ? dig_val : b_q;
            dig_d      = dig_cnt;
            err_d      = err_q || ovf;
            tone_req_d = 1'b1;
            tone_idx_d = num;
          end
        end
        COMPUTE: begin
          it_d = it_q + 3'd1;
          if (op_q == OP_ADD || op_q == OP_SUB) begin
            result_d = op_q == OP_ADD ? {8'd0, a_q} + {8'd0, b_q} : {8'd0, a_q} - {8'd0, b_q};
            state_d  = DONE;
          end else if (!is_mul && b_q == 8'd0) begin
            result_d = 16'd0;
            err_d    = 1'b1;
            state_d  = DONE;
          end else begin
            acc_d = is_mul ? mul_acc : {8'd0, rem_n};
            sh_d  = {sh_q[6:0], !is_mul && ge};
            if (it_q == 3'd7) begin
              result_d = is_mul ? mul_acc : op_q == OP_DIV ? {8'd0, sh_q[6:0], ge} : {8'd0, rem_n};
              state_d  = DONE;
            end
          end
        end
        DONE: begin
          if (is_op && result_q[15:8] == 8'd0) begin
            state_d    = ENTER_B;
            a_d        = result_q[7:0];
            b_d        = 8'd0;
            dig_d      = 4'd0;
            op_d       = opt;
            tone_req_d = 1'b1;
            tone_idx_d = {1'b0, opt} + 4'd10;
          end else if (is_op) begin
            err_d = 1'b1;
          end else if (is_dig) begin
            state_d    = ENTER_A;
            a_d        = {4'd0, num};
            dig_d      = num != 4'd0 ? 4'd1 : 4'd0;
            err_d      = 1'b0;
            tone_req_d = 1'b1;
            tone_idx_d = num;
          end
        end
      endcase
    end
    operand_d = state_d == ENTER_B ? b_d : a_d;
    valid_d   = state_d == DONE;
    busy_d    = state_d == COMPUTE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ENTER_A;
      a_q        <= 8'd0;
      b_q        <= 8'd0;
      op_q       <= 3'd0;
      dig_q      <= 4'd0;
      acc_q      <= 16'd0;
      sh_q       <= 8'd0;
      it_q       <= 3'd0;
      result_q   <= 16'd0;
      err_q      <= 1'b0;
      tone_req_q <= 1'b0;
      tone_idx_q <= 4'd0;
      operand_q  <= 8'd0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      dig_q      <= dig_d;
      acc_q      <= acc_d;
      sh_q       <= sh_d;
      it_q       <= it_d;
      result_q   <= result_d;
      err_q      <= err_d;
      tone_req_q <= tone_req_d;
      tone_idx_q <= tone_idx_d;
      operand_q  <= operand_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign operand      = operand_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign err          = err_q;
  assign busy         = busy_q;
  assign tone_req     = tone_req_q;
  assign tone_idx     = tone_idx_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed keypad scenarios with literal expectations, then random key
// traffic checked every cycle against an arithmetic model of the calculator.
module tb_calc_sequencer;
  localparam int MAXD = 3;
  localparam int PA = 0, PB = 1, PC = 2, PD = 3;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [3:0]  num = 4'd0;
  logic        num_pressed = 1'b0, opt_pressed = 1'b0, submit = 1'b0, tone_ack = 1'b1;
  logic [2:0]  opt = 3'd0;
  logic [7:0]  operand;
  logic [15:0] result;
  logic        result_valid, err, busy, tone_req;
  logic [3:0]  tone_idx;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  calc_sequencer #(.MAX_DIGITS(MAXD)) dut (
    .clk(clk), .reset(rst_n), .num(num), .num_pressed(num_pressed), .opt(opt),
    .opt_pressed(opt_pressed), .submit(submit), .tone_ack(tone_ack), .operand(operand),
    .result(result), .result_valid(result_valid), .err(err), .busy(busy),
    .tone_req(tone_req), .tone_idx(tone_idx)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] mdl, input logic [31:0] exp);
    chk(nm, act, exp);
    chk({nm, "_model"}, mdl, exp);
  endtask

  // Reference model: phase, operands, and a precomputed answer released after the compute latency.
  int m_ph, m_a, m_b, m_op, m_cnt, m_res, m_err, m_left, m_pres, m_perr, m_req, m_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = PA; m_a = 0; m_b = 0; m_op = 0; m_cnt = 0; m_res = 0; m_err = 0;
      m_left = 0; m_pres = 0; m_perr = 0; m_req = 0; m_idx = 0;
    end else begin : step
      int cur, v, idx;
      bit acc;
      acc = 0; idx = 0;
      if (m_ph == PC) begin
        m_left--;
        if (m_left == 0) begin
          m_ph = PD; m_res = m_pres;
          if (m_perr) m_err = 1;
        end
      end else if (opt_pressed && opt >= 5) begin
        m_ph = PA; m_a = 0; m_b = 0; m_op = 0; m_cnt = 0; m_res = 0; m_err = 0;
        acc = 1; idx = 15;
      end else if (submit) begin
        if (m_ph == PA) begin
          m_res = m_a; m_ph = PD; acc = 1; idx = 15;
        end else if (m_ph == PB) begin
          m_ph = PC; acc = 1; idx = 15; m_perr = 0; m_left = 8;
          case (m_op)
            0: begin m_pres = m_a + m_b; m_left = 1; end
            1: begin m_pres = (m_a - m_b) & 'hFFFF; m_left = 1; end
            2: m_pres = m_a * m_b;
            default: begin
              if (m_b == 0) begin m_pres = 0; m_perr = 1; m_left = 1; end
              else m_pres = (m_op == 3) ? m_a / m_b : m_a % m_b;
            end
          endcase
        end
      end else if (opt_pressed) begin
        if (m_ph == PA || m_ph == PB) begin
          if (m_ph == PA) begin m_b = 0; m_cnt = 0; end
          m_op = int'(opt); m_ph = PB; acc = 1; idx = 10 + int'(opt);
        end else if (m_res <= 255) begin
          m_a = m_res; m_b = 0; m_cnt = 0; m_op = int'(opt); m_ph = PB; acc = 1; idx = 10 + int'(opt);
        end else m_err = 1;
      end else if (num_pressed && num <= 9) begin
        if (m_ph == PD) begin
          m_a = int'(num); m_cnt = (num != 0) ? 1 : 0; m_err = 0; m_ph = PA; acc = 1; idx = int'(num);
        end else if (m_cnt < MAXD) begin
          cur = (m_ph == PA) ? m_a : m_b;
          v = cur * 10 + int'(num);
          if (v != 0) m_cnt++;
          if (v > 255) begin v = 255; m_err = 1; end
          if (m_ph == PA) m_a = v; else m_b = v;
          acc = 1; idx = int'(num);
        end
      end
      if (acc) begin m_req = 1; m_idx = idx; end
      else if (tone_ack) m_req = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, m_ph == PC);
      chk("result_valid", result_valid, m_ph == PD);
      chk("err", err, m_err);
      chk("tone_req", tone_req, m_req);
      chk("tone_idx", tone_idx, m_idx);
      if (m_ph == PA || m_ph == PB) chk("operand", operand, (m_ph == PA) ? m_a : m_b);
      if (m_ph == PD) chk("result", result, m_res);
    end
  end

  task automatic key_num(input int n);
    num = 4'(n); num_pressed = 1'b1;
    @(negedge clk);
    num_pressed = 1'b0;
  endtask

  task automatic key_opt(input int o);
    opt = 3'(o); opt_pressed = 1'b1;
    @(negedge clk);
    opt_pressed = 1'b0;
  endtask

  task automatic key_sub();
    submit = 1'b1;
    @(negedge clk);
    submit = 1'b0;
  endtask

  task automatic wait_busy(output int c);
    c = 0;
    while (busy && c < 50) begin
      c++;
      @(negedge clk);
    end
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clk);
    chk("rst_operand", operand, 0);
    chk("rst_result", result, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tone_req", tone_req, 0);
    chk("rst_tone_idx", tone_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);

    key_num(1); key_num(2); key_num(3);
    pin("op123", operand, m_a, 123);
    key_num(4);
    pin("op_4th_ignored", operand, m_a, 123);
    chk("ignored_no_tone", tone_req, 0);
    key_opt(5); key_num(0); key_num(0); key_num(7);
    pin("op007", operand, m_a, 7);
    key_num(5); key_num(5);
    pin("clamp755", operand, m_a, 255);
    chk("clamp_err", err, 1);

    key_opt(5); key_num(2); key_num(5); key_opt(0); key_num(1); key_num(7);
    pin("opB17", operand, m_b, 17);
    key_sub();
    wait_busy(c);
    chk("busy_add_cycles", c, 1);
    pin("res42", result, m_res, 42);
    chk("valid42", result_valid, 1);
    key_opt(0);
    pin("chain_b0", operand, m_b, 0);
    key_num(8); key_sub();
    wait_busy(c);
    pin("res50", result, m_res, 50);

    key_opt(5); key_num(3); key_opt(1); key_num(5); key_sub();
    wait_busy(c);
    pin("resFFFE", result, m_res, 16'hFFFE);
    key_opt(2);
    chk("neg_chain_err", err, 1);
    chk("neg_chain_stay", result_valid, 1);
    chk("neg_chain_no_tone", tone_req, 0);

    key_opt(5); key_num(2); key_num(0); key_num(0); key_opt(2); key_num(2); key_num(0); key_num(0);
    key_sub();
    key_num(5);
    chk("busy_digit_no_tone", tone_req, 0);
    key_opt(5);
    chk("busy_clear_no_tone", tone_req, 0);
    chk("busy_clear_ignored", busy, 1);
    wait_busy(c);
    chk("busy_mul_cycles", c + 2, 8);
    pin("res40000", result, m_res, 40000);
    chk("mul_err", err, 0);

    key_opt(5); key_num(2); key_num(0); key_num(0); key_opt(3); key_num(7); key_sub();
    wait_busy(c);
    chk("busy_div_cycles", c, 8);
    pin("res_div", result, m_res, 28);
    key_opt(5); key_num(2); key_num(5); key_num(5); key_opt(4); key_num(7); key_sub();
    wait_busy(c);
    pin("res_mod", result, m_res, 3);
    key_opt(5); key_num(4); key_num(2); key_sub();
    chk("submitA_busy", busy, 0);
    pin("submitA_res", result, m_res, 42);
    chk("submitA_valid", result_valid, 1);

    key_opt(5); key_num(9); key_opt(3); key_num(0); key_sub();
    wait_busy(c);
    chk("busy_div0_cycles", c, 1);
    chk("div0_err", err, 1);
    pin("div0_res", result, m_res, 0);
    key_opt(6);
    chk("clr_err", err, 0);
    chk("clr_operand", operand, 0);
    chk("clr_tone_idx", tone_idx, 15);

    tone_ack = 1'b0;
    key_num(3);
    chk("pend_req1", tone_req, 1);
    chk("pend_idx3", tone_idx, 3);
    key_num(8);
    chk("pend_req2", tone_req, 1);
    chk("pend_idx8", tone_idx, 8);
    @(negedge clk);
    chk("pend_hold", tone_req, 1);
    tone_ack = 1'b1;
    key_num(1);
    chk("ack_and_key_req", tone_req, 1);
    chk("ack_and_key_idx", tone_idx, 1);
    pin("clamp381", operand, m_a, 255);
    @(negedge clk);
    chk("ack_clears", tone_req, 0);

    key_opt(5); key_num(9); key_opt(2); key_num(9); key_sub();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_valid_after_rst", result_valid, 0);
    end

    for (int i = 0; i < 4000; i++) begin
      num_pressed = ($urandom_range(0, 99) < 40);
      num         = 4'($urandom_range(0, 11));
      opt_pressed = ($urandom_range(0, 99) < 12);
      opt         = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      submit      = ($urandom_range(0, 99) < 8);
      tone_ack    = ($urandom_range(0, 1) == 1);
      rst_n       = ($urandom_range(0, 599) != 0);
      @(negedge clk);
    end
    num_pressed = 1'b0; opt_pressed = 1'b0; submit = 1'b0; tone_ack = 1'b1; rst_n = 1'b1;
    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
